transaction_ctrl: RTL and testbench
===================================

TRANSACTION_CTRL -- requirements
Module: transaction_ctrl

Interface
REQ-001 Parameter: FIFO_DEPTH, 8, depth of the transaction-layer FIFOs.
REQ-002 Parameter: THR_W, 3, threshold width in bits.
REQ-003 Parameter: AFULL_RST, 6, reset value of the almost-full threshold.
REQ-004 Parameter: AEMPTY_RST, 1, reset value of the almost-empty threshold.
REQ-005 Parameter: CNT_W, 5, per-port transfer counter width in bits.
REQ-006 Port: clk  in  1  single clock, all state updates on its rising edge.
REQ-007 Port: reset_L  in  1  synchronous, active-low reset.
REQ-008 Port: init  in  1  request to enter or stay in INIT.
REQ-009 Port: afull_thr_in  in  THR_W  almost-full threshold candidate.
REQ-010 Port: aempty_thr_in  in  THR_W  almost-empty threshold candidate.
REQ-011 Port: in_empty  in  4  empty flags of input FIFOs 0..3.
REQ-012 Port: out_empty  in  4  empty flags of output FIFOs 0..3.
REQ-013 Port: fifo_error  in  8  overflow/underflow flags, [3:0] input FIFOs, [7:4] output FIFOs.
REQ-014 Port: push_obs  in  4  arbiter push strobes toward output FIFOs 0..3.
REQ-015 Port: cnt_req / cnt_sel  in  1 / 2  counter read request and port select.
REQ-016 Port: state  out  3  current FSM state code.
REQ-017 Port: afull_thr / aempty_thr  out  THR_W  active thresholds distributed to the FIFOs.
REQ-018 Port: active_out, idle_out, error_out  out  1 each  decoded state flags.
REQ-019 Port: cnt_valid / cnt_data  out  1 / CNT_W  counter read response.

Function
REQ-020 The FSM SHALL use the encoding RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
REQ-021 RESET SHALL go to INIT on the first cycle with reset_L=1.
REQ-022 INIT SHALL stay in INIT while init=1, and go to IDLE when init=0.
REQ-023 IDLE SHALL go to ACTIVE when any in_empty bit is 0.
REQ-024 ACTIVE SHALL go to IDLE when in_empty=4'hF and out_empty=4'hF.
REQ-025 From IDLE and ACTIVE, init=1 SHALL force INIT.
REQ-026 From INIT, IDLE and ACTIVE, any fifo_error bit set SHALL force ERROR; error takes priority over init, which takes priority over the other transitions.
REQ-027 ERROR SHALL be absorbing, left only by reset.
REQ-028 Thresholds SHALL be loaded only on cycles in INIT with aempty_thr_in < afull_thr_in and afull_thr_in <= FIFO_DEPTH-1; otherwise the previous values are held.
REQ-029 A loaded threshold SHALL appear on the outputs on the next cycle.
REQ-030 active_out, idle_out and error_out SHALL be decoded from the state register, with zero added latency and at most one asserted.
REQ-031 All state transitions SHALL take effect one clock after the qualifying inputs.

Reset
REQ-032 Reset low at an edge SHALL set: state=RESET, afull_thr=AFULL_RST, aempty_thr=AEMPTY_RST, all flags 0, cnt_valid=0, cnt_data=0, all counters 0.
REQ-033 Reset SHALL win over every other event, including mid-transfer and while in ERROR.

Configuration
REQ-034 The macro TXN_CTRL_CNT_EN SHALL compile in the transfer counters.
REQ-035 When TXN_CTRL_CNT_EN is defined, there SHALL be four CNT_W counters.
REQ-036 Counter i SHALL increment on push_obs[i]=1 in any state except ERROR, saturate at all-ones, and clear on entry to INIT.
REQ-037 When TXN_CTRL_CNT_EN is defined, cnt_req=1 SHALL produce cnt_valid=1 for exactly one cycle on the next cycle, with cnt_data equal to counter cnt_sel sampled at the request edge.
REQ-038 When TXN_CTRL_CNT_EN is defined, a same-cycle push and request SHALL return the pre-increment value.
REQ-039 When TXN_CTRL_CNT_EN is undefined, there SHALL be no counters, cnt_valid and cnt_data SHALL be tied to 0, and cnt_req, cnt_sel and push_obs SHALL be ignored.

Verification
REQ-040 Reset, then init=1 for 3 cycles with afull_thr_in=5 and aempty_thr_in=2, then init=0 -> state 0,1,1,1,2; afull_thr=5 and aempty_thr=2 visible one cycle after the first INIT cycle.
REQ-041 In INIT, apply afull_thr_in=2, aempty_thr_in=3 -> thresholds stay at 6/1.
REQ-042 IDLE, in_empty=4'b1101 -> ACTIVE next cycle; then all empty flags =1 -> IDLE next cycle.
REQ-043 ACTIVE, fifo_error[5]=1 together with init=1 -> ERROR; remains ERROR with init toggling; reset_L=0 -> RESET.
REQ-044 With TXN_CTRL_CNT_EN: 33 pushes on port 2, then cnt_req with cnt_sel=2 -> cnt_valid for one cycle, cnt_data=31 (saturated); re-entering INIT clears it to 0.

Source files
------------

// File: rtl/transaction_ctrl.sv
// transaction_ctrl: transaction-layer control FSM. It also owns the FIFO
// almost-full/almost-empty thresholds.
// Define TXN_CTRL_CNT_EN to build in the per-port transfer counters and the
// counter read port. Without it, cnt_valid and cnt_data are tied low.
module transaction_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int THR_W      = 3,
    parameter int AFULL_RST  = 6,
    parameter int AEMPTY_RST = 1,
    parameter int CNT_W      = 5
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             init,
    input  logic [THR_W-1:0] afull_thr_in,
    input  logic [THR_W-1:0] aempty_thr_in,
    input  logic [3:0]       in_empty,
    input  logic [3:0]       out_empty,
    input  logic [7:0]       fifo_error,
    input  logic [3:0]       push_obs,
    input  logic             cnt_req,
    input  logic [1:0]       cnt_sel,
    output logic [2:0]       state,
    output logic [THR_W-1:0] afull_thr,
    output logic [THR_W-1:0] aempty_thr,
    output logic             active_out,
    output logic             idle_out,
    output logic             error_out,
    output logic             cnt_valid,
    output logic [CNT_W-1:0] cnt_data
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    localparam int MAX_THR = FIFO_DEPTH - 1;

    state_t state_q;
    logic   any_error;
    logic   thr_ok;

    assign any_error = |fifo_error;
    assign thr_ok    = (aempty_thr_in < afull_thr_in) &&
                       (int'(afull_thr_in) <= MAX_THR);

    // Control FSM: error beats init, and init beats the data-driven moves.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q <= ST_RESET;
        end else begin
            case (state_q)
                ST_RESET: state_q <= ST_INIT;
                ST_INIT: begin
                    if (any_error)  state_q <= ST_ERROR;
                    else if (!init) state_q <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (any_error)              state_q <= ST_ERROR;
                    else if (init)              state_q <= ST_INIT;
                    else if (in_empty != 4'hF)  state_q <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (any_error)  state_q <= ST_ERROR;
                    else if (init)  state_q <= ST_INIT;
                    else if (in_empty == 4'hF && out_empty == 4'hF)
                        state_q <= ST_IDLE;
                end
                ST_ERROR: state_q <= ST_ERROR;
                default:  state_q <= ST_RESET;
            endcase
        end
    end

    // Threshold registers: a candidate pair is accepted only while in INIT,
    // and only if it is consistent.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            afull_thr  <= THR_W'(AFULL_RST);
            aempty_thr <= THR_W'(AEMPTY_RST);
        end else if (state_q == ST_INIT && thr_ok) begin
            afull_thr  <= afull_thr_in;
            aempty_thr <= aempty_thr_in;
        end
    end

    // State code and one-hot flags decoded directly from the state register.
    always_comb begin
        state      = state_q;
        active_out = (state_q == ST_ACTIVE);
        idle_out   = (state_q == ST_IDLE);
        error_out  = (state_q == ST_ERROR);
    end

`ifdef TXN_CTRL_CNT_EN
    logic [CNT_W-1:0] cnt_q [4];
    logic             enter_init;

    // Counters clear on the edge that moves the FSM into INIT. These are the
    // same conditions as the INIT arcs above, minus staying in INIT.
    assign enter_init = (state_q == ST_RESET) ||
                        ((state_q == ST_IDLE || state_q == ST_ACTIVE) &&
                         !any_error && init);

    // Per-port saturating transfer counters. They are frozen while in ERROR.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (enter_init)
                    cnt_q[i] <= '0;
                else if (push_obs[i] && state_q != ST_ERROR && cnt_q[i] != '1)
                    cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    // Counter read port: a single-cycle response that carries the value held
    // before the edge on which the request was made.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            cnt_valid <= 1'b0;
            cnt_data  <= '0;
        end else begin
            cnt_valid <= cnt_req;
            if (cnt_req) cnt_data <= cnt_q[cnt_sel];
        end
    end
`else
    logic unused_cnt_inputs;
    assign unused_cnt_inputs = ^{push_obs, cnt_req, cnt_sel};
    assign cnt_valid = 1'b0;
    assign cnt_data  = '0;
`endif

endmodule

// File: tb/tb_transaction_ctrl.sv
// tb_transaction_ctrl: directed vectors for transaction_ctrl. The expected
// state, thresholds and counter responses are queued by the stimulus process.
// A separate monitor pops and compares them at each falling edge.
module tb_transaction_ctrl;

    logic       clk;
    logic       reset_L;
    logic       init;
    logic [2:0] afull_thr_in;
    logic [2:0] aempty_thr_in;
    logic [3:0] in_empty;
    logic [3:0] out_empty;
    logic [7:0] fifo_error;
    logic [3:0] push_obs;
    logic       cnt_req;
    logic [1:0] cnt_sel;
    logic [2:0] state;
    logic [2:0] afull_thr;
    logic [2:0] aempty_thr;
    logic       active_out;
    logic       idle_out;
    logic       error_out;
    logic       cnt_valid;
    logic [4:0] cnt_data;

    typedef struct {
        logic [2:0] st;
        logic [2:0] af;
        logic [2:0] ae;
    } exp_t;

    exp_t exp_q[$];
    int   cnt_q[$];
    int   checks = 0;
    int   errors = 0;

    transaction_ctrl #(
        .FIFO_DEPTH(8),
        .THR_W(3),
        .AFULL_RST(6),
        .AEMPTY_RST(1),
        .CNT_W(5)
    ) dut (
        .clk(clk),
        .reset_L(reset_L),
        .init(init),
        .afull_thr_in(afull_thr_in),
        .aempty_thr_in(aempty_thr_in),
        .in_empty(in_empty),
        .out_empty(out_empty),
        .fifo_error(fifo_error),
        .push_obs(push_obs),
        .cnt_req(cnt_req),
        .cnt_sel(cnt_sel),
        .state(state),
        .afull_thr(afull_thr),
        .aempty_thr(aempty_thr),
        .active_out(active_out),
        .idle_out(idle_out),
        .error_out(error_out),
        .cnt_valid(cnt_valid),
        .cnt_data(cnt_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("state", {5'd0, state}, {5'd0, e.st});
            chk("afull_thr", {5'd0, afull_thr}, {5'd0, e.af});
            chk("aempty_thr", {5'd0, aempty_thr}, {5'd0, e.ae});
            chk("flags", {5'd0, active_out, idle_out, error_out},
                {5'd0, e.st == 3'd3, e.st == 3'd2, e.st == 3'd4});
        end
        if (cnt_valid === 1'b1) begin
            if (cnt_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cnt_valid: got 1 expected 0 (t=%0t)", $time);
            end else begin
                chk("cnt_data", {3'd0, cnt_data}, 8'(cnt_q.pop_front()));
            end
        end
`ifndef TXN_CTRL_CNT_EN
        chk("cnt_tied", {2'd0, cnt_valid, cnt_data}, 8'd0);
`endif
    end

    // One clock of stimulus. The expectation describes the DUT after this edge.
    task automatic tick(input logic [2:0] es, input logic [2:0] ea,
                        input logic [2:0] ee, input int ecnt = -1);
        @(posedge clk);
        exp_q.push_back('{st: es, af: ea, ae: ee});
`ifdef TXN_CTRL_CNT_EN
        if (cnt_req) cnt_q.push_back(ecnt);
`endif
        #1;
    endtask

    initial begin
        reset_L = 1'b0; init = 1'b0;
        afull_thr_in = 3'd2; aempty_thr_in = 3'd3;
        in_empty = 4'hF; out_empty = 4'hF; fifo_error = 8'h00;
        push_obs = 4'h0; cnt_req = 1'b0; cnt_sel = 2'd0;

        // Reset, then invalid and boundary threshold candidates in INIT
        tick(0, 6, 1);
        tick(0, 6, 1);
        reset_L = 1'b1; init = 1'b1;
        tick(1, 6, 1);
        tick(1, 6, 1);                        // aempty > afull: held
        afull_thr_in = 3'd4; aempty_thr_in = 3'd4;
        tick(1, 6, 1);                        // equal: held
        afull_thr_in = 3'd7; aempty_thr_in = 3'd0;
        tick(1, 7, 0);                        // afull = depth-1: loaded
        afull_thr_in = 3'd3; aempty_thr_in = 3'd2; fifo_error = 8'h01;
        tick(4, 3, 2);                        // error beats init in INIT
        fifo_error = 8'h00;

        // Reset, INIT for three cycles, then IDLE
        reset_L = 1'b0;
        tick(0, 6, 1);
        reset_L = 1'b1; afull_thr_in = 3'd5; aempty_thr_in = 3'd2;
        tick(1, 6, 1);
        tick(1, 5, 2);
        tick(1, 5, 2);
        init = 1'b0;
        tick(2, 5, 2);
        afull_thr_in = 3'd7; aempty_thr_in = 3'd0;
        tick(2, 5, 2);                        // no load outside INIT
        afull_thr_in = 3'd5; aempty_thr_in = 3'd2;

        // IDLE <-> ACTIVE and init from IDLE/ACTIVE
        in_empty = 4'b1101;
        tick(3, 5, 2);
        in_empty = 4'hF; out_empty = 4'b0111;
        tick(3, 5, 2);                        // output side not drained yet
        out_empty = 4'hF;
        tick(2, 5, 2);
        tick(2, 5, 2);
        init = 1'b1;
        tick(1, 5, 2);
        init = 1'b0; in_empty = 4'b1110;
        tick(2, 5, 2);
        tick(3, 5, 2);
        init = 1'b1;
        tick(1, 5, 2);
        init = 1'b0; in_empty = 4'h0;
        tick(2, 5, 2);
        tick(3, 5, 2);

        // ERROR from ACTIVE wins over init, is absorbing, and yields to reset
        fifo_error = 8'h20; init = 1'b1;
        tick(4, 5, 2);
        fifo_error = 8'h00; init = 1'b0;
        tick(4, 5, 2);
        init = 1'b1;
        tick(4, 5, 2);
        init = 1'b0; in_empty = 4'hF;
        tick(4, 5, 2);
        reset_L = 1'b0;
        tick(0, 6, 1);

        // Transfer counters on port 2: read-during-push, saturation, clear on INIT
        reset_L = 1'b1; init = 1'b1;
        tick(1, 6, 1);
        init = 1'b0;
        tick(2, 5, 2);
        push_obs = 4'b0100;
        for (int i = 0; i < 3; i++) tick(2, 5, 2);
        cnt_req = 1'b1; cnt_sel = 2'd2;
        tick(2, 5, 2, 3);                     // pre-increment value
        cnt_req = 1'b0;
        for (int i = 0; i < 29; i++) tick(2, 5, 2);
        push_obs = 4'b0000; cnt_req = 1'b1; cnt_sel = 2'd2;
        tick(2, 5, 2, 31);                    // 33 pushes saturate at 31
        cnt_sel = 2'd1;
        tick(2, 5, 2, 0);
        cnt_req = 1'b0; init = 1'b1;
        tick(1, 5, 2);
        cnt_req = 1'b1; cnt_sel = 2'd2;
        tick(1, 5, 2, 0);                     // cleared on entry to INIT
        cnt_req = 1'b0; init = 1'b0;
        tick(2, 5, 2);

        // Port 3 counts in IDLE, then freezes in ERROR
        push_obs = 4'b1000;
        tick(2, 5, 2);
        tick(2, 5, 2);
        fifo_error = 8'h80;
        tick(4, 5, 2);                        // last counted push (was IDLE)
        fifo_error = 8'h00;
        for (int i = 0; i < 3; i++) tick(4, 5, 2);
        push_obs = 4'b0000; cnt_req = 1'b1; cnt_sel = 2'd3;
        tick(4, 5, 2, 3);
        cnt_req = 1'b0; reset_L = 1'b0;
        tick(0, 6, 1);
        tick(0, 6, 1);

        @(negedge clk);
        #1;
        chk("exp_q_drained", 8'(exp_q.size()), 8'd0);
        chk("cnt_q_drained", 8'(cnt_q.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
